// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, 1-entry fetch buffer.
// Optional misaligned-fetch trap enabled by defining IF_ALIGN_CHK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        if_exc
);

    typedef enum logic [2:0] {
        S_START,
        S_ISSUE,
        S_WAIT,
`ifdef IF_ALIGN_CHK_EN
        S_DRAIN,
        S_HALT
`else
        S_DRAIN
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic        buf_valid;
    logic        can_issue;
    logic        misaligned;
`ifdef IF_ALIGN_CHK_EN
    logic        exc_q;
`endif

    // Issuing only when the buffer is empty at the next edge guarantees room for the response.
    always_comb begin
        can_issue  = !buf_valid || !stall;
`ifdef IF_ALIGN_CHK_EN
        misaligned = (pc[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        imem_req   = (state == S_ISSUE) && can_issue && !redirect && !misaligned;
    end

    assign imem_addr = pc;
    assign if_instr  = buf_instr;
    assign if_pc4    = buf_pc4;
    assign if_valid  = buf_valid;
`ifdef IF_ALIGN_CHK_EN
    assign if_exc    = exc_q;
`else
    assign if_exc    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_START;
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc4   <= '0;
            buf_valid <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
            exc_q     <= 1'b0;
`endif
        end else begin
            if (buf_valid && !stall) begin
                buf_valid <= 1'b0;
                buf_instr <= NOP_INSTR;
                buf_pc4   <= '0;
            end
            if (redirect) begin
                // Redirect wins over stall and every FSM action; an in-flight response gets drained.
                pc        <= redirect_pc;
                buf_valid <= 1'b0;
                buf_instr <= NOP_INSTR;
                buf_pc4   <= '0;
`ifdef IF_ALIGN_CHK_EN
                exc_q     <= 1'b0;
`endif
                case (state)
                    S_WAIT, S_DRAIN: state <= imem_rvalid ? S_ISSUE : S_DRAIN;
                    default:         state <= S_ISSUE;
                endcase
            end else begin
                case (state)
                    S_START: state <= S_ISSUE;
                    S_ISSUE: begin
`ifdef IF_ALIGN_CHK_EN
                        if (misaligned) begin
                            if (can_issue) begin
                                buf_instr <= NOP_INSTR;
                                buf_pc4   <= pc + 32'd4;
                                buf_valid <= 1'b1;
                                exc_q     <= 1'b1;
                                state     <= S_HALT;
                            end
                        end else
`endif
                        if (imem_req && imem_gnt) begin
                            req_pc <= pc;
                            pc     <= pc + 32'd4;
                            state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            buf_instr <= imem_rdata;
                            buf_pc4   <= req_pc + 32'd4;
                            buf_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_rvalid) state <= S_ISSUE;
                    end
`ifdef IF_ALIGN_CHK_EN
                    S_HALT: state <= S_HALT;
`endif
                    default: state <= S_START;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic against a flag-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0040;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef IF_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk, reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_instr, if_pc4;
    logic        if_valid, if_exc;

    int total = 0;
    int bad   = 0;

    // memory responder
    bit          rand_mode = 0;
    int          cfg_gnt_wait = 0;
    int          cfg_lat = 1;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          req_wait;

    // reference model
    logic [31:0] m_pc, m_reqpc, m_instr, m_pc4;
    bit          m_started, m_out, m_killed, m_halted, m_bv, m_exc;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid), .if_exc(if_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_req();
        return m_started && !m_out && !m_halted && (!m_bv || !stall) && !redirect &&
               !(ALIGN && (m_pc[1:0] != 2'b00));
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_reqpc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = '0;
        m_started = 0; m_out = 0; m_killed = 0; m_halted = 0; m_bv = 0; m_exc = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0; req_wait = 0;
    endtask

    task automatic drive_mem();
        if (rand_mode) imem_gnt = ($urandom_range(0, 99) < 60);
        else           imem_gnt = (req_wait >= cfg_gnt_wait);
        imem_rvalid = mem_busy && (mem_cnt == 1);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    endtask

    task automatic tick();
        bit req, can, mis;
        @(posedge clk);
        req = model_req();
        can = !m_bv || !stall;
        mis = ALIGN && (m_pc[1:0] != 2'b00);
        if (mem_busy) begin
            if (imem_rvalid) mem_busy = 0;
            else             mem_cnt--;
        end
        if (req && imem_gnt) begin
            mem_busy = 1; mem_addr = m_pc; req_wait = 0;
            mem_cnt  = rand_mode ? int'($urandom_range(1, 4)) : cfg_lat;
        end else if (req) req_wait++;
        if (m_bv && !stall) m_bv = 0;
        if (redirect) begin
            m_pc = redirect_pc; m_bv = 0; m_exc = 0; m_halted = 0; m_started = 1;
            if (m_out) begin
                if (imem_rvalid) begin m_out = 0; m_killed = 0; end
                else m_killed = 1;
            end
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_out) begin
            if (imem_rvalid) begin
                if (!m_killed) begin m_bv = 1; m_instr = imem_rdata; m_pc4 = m_reqpc + 32'd4; end
                m_out = 0; m_killed = 0;
            end
        end else if (m_halted) begin
            m_halted = 1;
        end else if (mis) begin
            if (can) begin m_bv = 1; m_instr = NOP_INSTR; m_pc4 = m_pc + 32'd4; m_exc = 1; m_halted = 1; end
        end else if (req && imem_gnt) begin
            m_reqpc = m_pc; m_pc = m_pc + 32'd4; m_out = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 0; redirect = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit got;
        reset = 1'b1; stall = 0; redirect = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        @(negedge clk); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
        total++; if (if_instr !== NOP_INSTR) begin bad++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP_INSTR); end
        total++; if (if_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h expected 0", if_pc4); end
        total++; if (if_valid !== 1'b0 || if_exc !== 1'b0) begin bad++; $display("FAIL reset_flags: got valid=%b exc=%b expected 0 0", if_valid, if_exc); end
        // reset in the middle of a transaction, then a stale response word
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 3;
        for (int k = 0; k < 6; k++) begin
            drive_mem(); #1;
            got = imem_req && imem_gnt;
            tick();
            if (got) break;
        end
        reset = 1'b1; #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin bad++; $display("FAIL midreset: got req=%b addr=%h expected 0 %h", imem_req, imem_addr, RESET_PC); end
        @(negedge clk);
        model_reset(); reset = 1'b0;
        drive_mem(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        drive_mem(); #1;
        total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL stale_rvalid: got valid=%b req=%b addr=%h expected 0 1 %h", if_valid, imem_req, imem_addr, RESET_PC);
        end
        tick();
    endtask

    task automatic test_stream();
        int ngnt, nval;
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 1;
        ngnt = 0; nval = 0;
        for (int i = 0; i < 14; i++) begin
            drive_mem(); #1;
            if (imem_req && imem_gnt) begin
                total++;
                if (imem_addr !== RESET_PC + 32'(4 * ngnt)) begin bad++; $display("FAIL stream_addr: got %h expected %h", imem_addr, RESET_PC + 32'(4 * ngnt)); end
                ngnt++;
            end
            if (if_valid) begin
                total++;
                if (if_pc4 !== RESET_PC + 32'(4 * (nval + 1)) || if_instr !== mem_word(RESET_PC + 32'(4 * nval))) begin
                    bad++; $display("FAIL stream_data: got %h/%h expected %h/%h", if_instr, if_pc4, mem_word(RESET_PC + 32'(4 * nval)), RESET_PC + 32'(4 * (nval + 1)));
                end
                nval++;
            end
            tick();
        end
        total++; if (ngnt != 7) begin bad++; $display("FAIL stream_grants: got %0d expected 7", ngnt); end
        total++; if (nval != 6) begin bad++; $display("FAIL stream_valids: got %0d expected 6", nval); end
    endtask

    task automatic test_stall_full();
        bit found;
        logic [31:0] ci, cp;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (if_valid) begin found = 1; break; end
            drive_mem(); tick();
        end
        total++; if (!found) begin bad++; $display("FAIL stall_fill: got valid=0 expected 1"); end
        ci = if_instr; cp = if_pc4; stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_mem(); #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b expected 0", imem_req); end
            total++; if (if_valid !== 1'b1 || if_instr !== ci || if_pc4 !== cp) begin
                bad++; $display("FAIL stall_hold: got %b %h %h expected 1 %h %h", if_valid, if_instr, if_pc4, ci, cp);
            end
            tick();
        end
        stall = 1'b0;
        drive_mem(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== cp) begin bad++; $display("FAIL stall_release: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, cp); end
        tick();
    endtask

    task automatic test_delayed_gnt();
        logic [31:0] ca;
        int lat;
        do_reset(); cfg_gnt_wait = 3; cfg_lat = 4;
        for (int k = 0; k < 6; k++) begin
            drive_mem(); #1;
            if (imem_req) break;
            tick();
        end
        ca = imem_addr;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin drive_mem(); #1; end
            total++; if (imem_req !== 1'b1 || imem_addr !== ca) begin bad++; $display("FAIL gnt_hold: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, ca); end
            tick();
        end
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (if_valid) break;
            drive_mem(); #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wait_req: got %b expected 0", imem_req); end
            tick(); lat++;
        end
        total++; if (lat != 4) begin bad++; $display("FAIL resp_latency: got %0d expected 4", lat); end
        total++; if (if_pc4 !== ca + 32'd4 || if_instr !== mem_word(ca)) begin
            bad++; $display("FAIL resp_data: got %h/%h expected %h/%h", if_instr, if_pc4, mem_word(ca), ca + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit got, seen;
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 3;
        for (int k = 0; k < 6; k++) begin
            drive_mem(); #1;
            got = imem_req && imem_gnt;
            tick();
            if (got) break;
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        drive_mem(); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req: got %b expected 0", imem_req); end
        tick(); redirect = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            drive_mem(); #1;
            if (imem_req && imem_gnt) begin
                seen = 1;
                total++; if (imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL redir_addr: got %h expected 00000100", imem_addr); end
                tick(); break;
            end
            total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_drop: got valid=%b expected 0", if_valid); end
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL redir_timeout: got no grant expected one"); end
        for (int k = 0; k < 6; k++) begin
            if (if_valid) break;
            drive_mem(); tick();
        end
        total++; if (if_valid !== 1'b1 || if_pc4 !== 32'h0000_0104 || if_instr !== mem_word(32'h100)) begin
            bad++; $display("FAIL redir_resp: got %b %h %h expected 1 %h 00000104", if_valid, if_instr, if_pc4, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_stall();
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 1;
        for (int k = 0; k < 10; k++) begin
            if (if_valid) break;
            drive_mem(); tick();
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        drive_mem(); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rs_req: got %b expected 0", imem_req); end
        tick(); redirect = 1'b0;
        total++; if (if_valid !== 1'b0 || if_pc4 !== 32'h0 || if_instr !== NOP_INSTR) begin
            bad++; $display("FAIL rs_flush: got %b %h %h expected 0 %h 0", if_valid, if_instr, if_pc4, NOP_INSTR);
        end
        drive_mem(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL rs_fetch: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr); end
        tick(); stall = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] a0, a1, p0;
        int ng;
        bit pv;
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        drive_mem(); tick(); redirect = 1'b0;
        ng = 0; pv = 0; a0 = 'x; a1 = 'x; p0 = 'x;
        for (int k = 0; k < 8; k++) begin
            drive_mem(); #1;
            if (imem_req && imem_gnt) begin
                if (ng == 0) a0 = imem_addr; else if (ng == 1) a1 = imem_addr;
                ng++;
            end
            if (if_valid && !pv) begin p0 = if_pc4; pv = 1; end
            tick();
        end
        total++; if (a0 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a0: got %h expected fffffffc", a0); end
        total++; if (a1 !== 32'h0) begin bad++; $display("FAIL wrap_a1: got %h expected 00000000", a1); end
        total++; if (p0 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h expected 00000000", p0); end
    endtask

`ifdef IF_ALIGN_CHK_EN
    task automatic test_align();
        do_reset(); cfg_gnt_wait = 0; cfg_lat = 1;
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        drive_mem(); tick(); redirect = 1'b0;
        drive_mem(); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL align_req: got %b expected 0", imem_req); end
        stall = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_exc !== 1'b1 || if_instr !== NOP_INSTR || if_pc4 !== 32'h0000_0106) begin
            bad++; $display("FAIL align_trap: got %b %b %h %h expected 1 1 %h 00000106", if_valid, if_exc, if_instr, if_pc4, NOP_INSTR);
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_mem(); #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req: got %b expected 0", imem_req); end
            tick();
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        drive_mem(); tick(); redirect = 1'b0;
        total++; if (if_exc !== 1'b0) begin bad++; $display("FAIL align_clear: got %b expected 0", if_exc); end
        drive_mem(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL align_resume: got req=%b addr=%h expected 1 00000200", imem_req, imem_addr); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] rr, ei, ep;
        bit er;
        rand_mode = 1;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            ei = m_bv ? m_instr : NOP_INSTR;
            ep = m_bv ? m_pc4 : 32'h0;
            total++; if (if_valid !== m_bv) begin bad++; $display("FAIL rnd_valid @%0d: got %b expected %b", n, if_valid, m_bv); end
            total++; if (if_instr !== ei) begin bad++; $display("FAIL rnd_instr @%0d: got %h expected %h", n, if_instr, ei); end
            total++; if (if_pc4 !== ep) begin bad++; $display("FAIL rnd_pc4 @%0d: got %h expected %h", n, if_pc4, ep); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr @%0d: got %h expected %h", n, imem_addr, m_pc); end
            total++; if (if_exc !== m_exc) begin bad++; $display("FAIL rnd_exc @%0d: got %b expected %b", n, if_exc, m_exc); end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 6);
            rr = $urandom;
            redirect_pc = ($urandom_range(0, 9) == 0) ? rr : (rr & 32'hFFFF_FFFC);
            drive_mem(); #1;
            er = model_req();
            total++; if (imem_req !== er) begin bad++; $display("FAIL rnd_req @%0d: got %b expected %b", n, imem_req, er); end
            tick();
        end
        rand_mode = 0; stall = 0; redirect = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall_full();
        test_delayed_gnt();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
`ifdef IF_ALIGN_CHK_EN
        test_align();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
